// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the quadrature NCO:
//   - quadrant encoding of the top two phase-address bits
//   - sample_peak(): peak amplitude of a signed sample of a given width
//   - lut_entry(): value of quarter-wave LUT entry i, used to build the ROM
//     and by any behavioural model of the oscillator
// -----------------------------------------------------------------------------
package nco_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t QUAD_0 = 2'd0;  // [0, 90) degrees
  localparam quad_t QUAD_1 = 2'd1;  // [90, 180)
  localparam quad_t QUAD_2 = 2'd2;  // [180, 270)
  localparam quad_t QUAD_3 = 2'd3;  // [270, 360)

  // Largest magnitude a signed sample may take; leaving -2^(w-1) unused
  // means negation of any table value can never overflow.
  function automatic int sample_peak(input int out_w);
    return (32'sd1 <<< (out_w - 32'sd1)) - 32'sd1;
  endfunction

  // Quarter-wave entry i for a full circle of 2^addr_w steps. The half-step
  // offset makes the table symmetric, so mirroring an index with ~idx lands
  // exactly on the reflected angle and no endpoint entry is needed.
  function automatic int lut_entry(input int i, input int addr_w, input int out_w);
    real ang;
    real val;
    ang = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(32'sd1 <<< addr_w);
    val = real'(sample_peak(out_w)) * $sin(ang);
    return $rtoi(val + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_lut.sv
// -----------------------------------------------------------------------------
// quarter_sine_lut
// Quarter-wave sine ROM with two independent read ports. Block-ROM style:
// the read addresses are registered, then the read data is registered, so a
// value appears two edges after its address is presented.
//   clk, rst_n        clock, asynchronous active-low reset
//   addr_a, addr_b    quarter-wave index per port (ROM_ADDR_WIDTH-2 bits)
//   data_a, data_b    non-negative table magnitude per port
// -----------------------------------------------------------------------------
module quarter_sine_lut
  import nco_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int OUTPUT_WIDTH   = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ROM_ADDR_WIDTH-3:0] addr_a,
  input  logic [ROM_ADDR_WIDTH-3:0] addr_b,
  output logic [OUTPUT_WIDTH-1:0]   data_a,
  output logic [OUTPUT_WIDTH-1:0]   data_b
);

  localparam int IDX_W = ROM_ADDR_WIDTH - 2;
  localparam int DEPTH = 32'sd1 <<< IDX_W;

  logic [OUTPUT_WIDTH-1:0] rom_s [DEPTH];

  logic [IDX_W-1:0]        addr_a_d, addr_a_q;
  logic [IDX_W-1:0]        addr_b_d, addr_b_q;
  logic [OUTPUT_WIDTH-1:0] data_a_d, data_a_q;
  logic [OUTPUT_WIDTH-1:0] data_b_d, data_b_q;

  // Table contents are elaboration-time constants.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom_s[g] = OUTPUT_WIDTH'(lut_entry(g, ROM_ADDR_WIDTH, OUTPUT_WIDTH));
  end

  // Next-state for the address and data registers of both ports
  always_comb begin
    addr_a_d = addr_a;
    addr_b_d = addr_b;
    data_a_d = rom_s[addr_a_q];
    data_b_d = rom_s[addr_b_q];
  end

  // Address and data registers of both read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_q <= {IDX_W{1'b0}};
      addr_b_q <= {IDX_W{1'b0}};
      data_a_q <= {OUTPUT_WIDTH{1'b0}};
      data_b_q <= {OUTPUT_WIDTH{1'b0}};
    end else begin
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/nco_iq.sv
// -----------------------------------------------------------------------------
// nco_iq
// Quadrature NCO: phase accumulator with programmable frequency word and
// phase offset, quarter-wave LUT lookup with quadrant mirroring, producing
// signed cosine (I) and sine (Q) samples three edges after launch.
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    each edge with en=1 advances phase, launches a sample
//   phase_clr             synchronous accumulator clear
//   cfg_valid/cfg_ready   configuration handshake
//   cfg_fcw, cfg_poff     new frequency word and phase offset
//   cfg_restart           accepted config also clears the accumulator
//   out_valid             sample valid
//   cos_out, sin_out      signed I / Q samples (hold while out_valid=0)
// -----------------------------------------------------------------------------
module nco_iq
  import nco_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int OUTPUT_WIDTH   = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           phase_clr,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [PHASE_WIDTH-1:0]         cfg_fcw,
  input  logic [PHASE_WIDTH-1:0]         cfg_poff,
  input  logic                           cfg_restart,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] cos_out,
  output logic signed [OUTPUT_WIDTH-1:0] sin_out
);

  localparam int IDX_W = ROM_ADDR_WIDTH - 2;

  // Configuration and accumulator
  logic                   cfg_ready_d, cfg_ready_q;
  logic [PHASE_WIDTH-1:0] fcw_d, fcw_q;
  logic [PHASE_WIDTH-1:0] poff_d, poff_q;
  logic [PHASE_WIDTH-1:0] acc_d, acc_q;
  logic                   cfg_accept_s;
  logic [ROM_ADDR_WIDTH-1:0] phase_addr_s;

  // S1: sampled phase address
  logic [ROM_ADDR_WIDTH-1:0] addr1_d, addr1_q;
  logic                      v1_d, v1_q;

  // Quadrant decode of the S1 address
  quad_t            quad_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] sin_idx_s, cos_idx_s;
  logic             sin_mirror_s, cos_mirror_s;
  logic             sin_neg_s, cos_neg_s;

  // S2: sign flags travel alongside the two-edge ROM read
  logic sneg_a_d, sneg_a_q, cneg_a_d, cneg_a_q, v2a_d, v2a_q;
  logic sneg_b_d, sneg_b_q, cneg_b_d, cneg_b_q, v2b_d, v2b_q;
  logic [OUTPUT_WIDTH-1:0] lut_sin_s, lut_cos_s;

  // S3: outputs
  logic signed [OUTPUT_WIDTH-1:0] sin_d, sin_q, cos_d, cos_q;
  logic                           out_valid_d, out_valid_q;

  assign cfg_accept_s = cfg_valid && cfg_ready_q;

  // Only the top ROM_ADDR_WIDTH bits of acc+poff address the table.
  assign phase_addr_s = ROM_ADDR_WIDTH'((acc_q + poff_q) >> (PHASE_WIDTH - ROM_ADDR_WIDTH));

  // Config registers, accumulator and S1 next-state
  always_comb begin
    cfg_ready_d = 1'b1;
    fcw_d       = fcw_q;
    poff_d      = poff_q;
    acc_d       = acc_q;
    addr1_d     = addr1_q;
    v1_d        = en;

    if (cfg_accept_s) begin
      fcw_d  = cfg_fcw;
      poff_d = cfg_poff;
    end else begin
      fcw_d  = fcw_q;
      poff_d = poff_q;
    end

    // A clear wins over the increment; the launched sample still uses the
    // pre-clear phase because addr1_d is formed from acc_q.
    if (phase_clr || (cfg_accept_s && cfg_restart)) begin
      acc_d = {PHASE_WIDTH{1'b0}};
    end else if (en) begin
      acc_d = acc_q + fcw_q;
    end else begin
      acc_d = acc_q;
    end

    if (en) begin
      addr1_d = phase_addr_s;
    end else begin
      addr1_d = addr1_q;
    end
  end

  // Config, accumulator and S1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      fcw_q       <= {PHASE_WIDTH{1'b0}};
      poff_q      <= {PHASE_WIDTH{1'b0}};
      acc_q       <= {PHASE_WIDTH{1'b0}};
      addr1_q     <= {ROM_ADDR_WIDTH{1'b0}};
      v1_q        <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      fcw_q       <= fcw_d;
      poff_q      <= poff_d;
      acc_q       <= acc_d;
      addr1_q     <= addr1_d;
      v1_q        <= v1_d;
    end
  end

  assign quad_s = addr1_q[ROM_ADDR_WIDTH-1 -: 2];
  assign idx_s  = addr1_q[IDX_W-1:0];

  // Quadrant mirroring: cosine is the sine rule applied one quadrant ahead
  always_comb begin
    sin_mirror_s = 1'b0;
    sin_neg_s    = 1'b0;
    cos_mirror_s = 1'b1;
    cos_neg_s    = 1'b0;
    case (quad_s)
      QUAD_0: begin
        sin_mirror_s = 1'b0; sin_neg_s = 1'b0;
        cos_mirror_s = 1'b1; cos_neg_s = 1'b0;
      end
      QUAD_1: begin
        sin_mirror_s = 1'b1; sin_neg_s = 1'b0;
        cos_mirror_s = 1'b0; cos_neg_s = 1'b1;
      end
      QUAD_2: begin
        sin_mirror_s = 1'b0; sin_neg_s = 1'b1;
        cos_mirror_s = 1'b1; cos_neg_s = 1'b1;
      end
      QUAD_3: begin
        sin_mirror_s = 1'b1; sin_neg_s = 1'b1;
        cos_mirror_s = 1'b0; cos_neg_s = 1'b0;
      end
      default: begin
        sin_mirror_s = 1'b0; sin_neg_s = 1'b0;
        cos_mirror_s = 1'b1; cos_neg_s = 1'b0;
      end
    endcase
    sin_idx_s = sin_mirror_s ? ~idx_s : idx_s;
    cos_idx_s = cos_mirror_s ? ~idx_s : idx_s;
  end

  quarter_sine_lut #(
    .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH),
    .OUTPUT_WIDTH   (OUTPUT_WIDTH)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (sin_idx_s),
    .addr_b (cos_idx_s),
    .data_a (lut_sin_s),
    .data_b (lut_cos_s)
  );

  // S2 flag pipeline next-state and S3 sign application
  always_comb begin
    v2a_d       = v1_q;
    sneg_a_d    = sin_neg_s;
    cneg_a_d    = cos_neg_s;
    v2b_d       = v2a_q;
    sneg_b_d    = sneg_a_q;
    cneg_b_d    = cneg_a_q;
    out_valid_d = v2b_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    if (v2b_q) begin
      sin_d = sneg_b_q ? -$signed(lut_sin_s) : $signed(lut_sin_s);
      cos_d = cneg_b_q ? -$signed(lut_cos_s) : $signed(lut_cos_s);
    end else begin
      sin_d = sin_q;
      cos_d = cos_q;
    end
  end

  // S2 flag registers and S3 output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2a_q       <= 1'b0;
      sneg_a_q    <= 1'b0;
      cneg_a_q    <= 1'b0;
      v2b_q       <= 1'b0;
      sneg_b_q    <= 1'b0;
      cneg_b_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sin_q       <= {OUTPUT_WIDTH{1'b0}};
      cos_q       <= {OUTPUT_WIDTH{1'b0}};
    end else begin
      v2a_q       <= v2a_d;
      sneg_a_q    <= sneg_a_d;
      cneg_a_q    <= cneg_a_d;
      v2b_q       <= v2b_d;
      sneg_b_q    <= sneg_b_d;
      cneg_b_q    <= cneg_b_d;
      out_valid_q <= out_valid_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign out_valid = out_valid_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;

endmodule

// File: tb/tb_nco_iq.sv
// -----------------------------------------------------------------------------
// tb_nco_iq
// Directed bench for nco_iq with PHASE_WIDTH=16, ROM_ADDR_WIDTH=8,
// OUTPUT_WIDTH=12. Expected samples come from hand-tabulated values or from a
// phase-to-sample reference built on nco_pkg::lut_entry.
// -----------------------------------------------------------------------------
module tb_nco_iq;
  import nco_pkg::*;

  localparam int PW  = 16;
  localparam int RAW = 8;
  localparam int OW  = 12;

  logic                 clk = 1'b0;
  logic                 rst_n, en, phase_clr, cfg_valid, cfg_ready, cfg_restart;
  logic [PW-1:0]        cfg_fcw, cfg_poff;
  logic                 out_valid;
  logic signed [OW-1:0] cos_out, sin_out;

  int checks   = 0;
  int failures = 0;
  int sq[$];
  int cq[$];

  always #5 clk = ~clk;

  nco_iq #(.PHASE_WIDTH(PW), .ROM_ADDR_WIDTH(RAW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fcw(cfg_fcw),
    .cfg_poff(cfg_poff), .cfg_restart(cfg_restart), .out_valid(out_valid),
    .cos_out(cos_out), .sin_out(sin_out)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference sine of a 16-bit phase: quadrant mirror/negate of lut_entry.
  function automatic int ref_sin(input logic [PW-1:0] p);
    int a, q, idx, n, v;
    n   = 1 << (RAW - 2);
    a   = int'(p >> (PW - RAW));
    q   = a / n;
    idx = a % n;
    case (q)
      0:       v =  lut_entry(idx, RAW, OW);
      1:       v =  lut_entry(n - 1 - idx, RAW, OW);
      2:       v = -lut_entry(idx, RAW, OW);
      default: v = -lut_entry(n - 1 - idx, RAW, OW);
    endcase
    return v;
  endfunction

  // Cosine is sine a quarter turn ahead.
  function automatic int ref_cos(input logic [PW-1:0] p);
    logic [PW-1:0] pp;
    pp = p + 16'h4000;
    return ref_sin(pp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      sq.push_back(int'(sin_out));
      cq.push_back(int'(cos_out));
    end
  endtask

  task automatic send_cfg(input logic [PW-1:0] fcw, input logic [PW-1:0] poff,
                          input logic restart);
    cfg_fcw     = fcw;
    cfg_poff    = poff;
    cfg_restart = restart;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    cfg_restart = 1'b0;
  endtask

  task automatic clear_cap();
    sq.delete();
    cq.delete();
  endtask

  // Watchdog: the stimulus is a fixed number of cycles, so this only fires
  // if simulation stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sin_tbl[4]  = '{25, 2047, -25, -2047};
    int cos_tbl[4]  = '{2047, -25, -2047, 25};
    int cos90[4]    = '{-25, -2047, 25, 2047};
    int ph4[17]     = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400,
                        16'h0500, 16'h0600, 16'h0700, 16'h0800, 16'h0900,
                        16'h0A00, 16'h0B00, 16'h0E00, 16'h1100, 16'h1400,
                        16'h2000, 16'h2300};
    logic en_pat[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic clr_pat[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic vld_pat[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int ph5[3]       = '{16'h0000, 16'h1000, 16'h0000};
    int bad_amp;
    int e;

    rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; cfg_valid = 1'b0;
    cfg_restart = 1'b0; cfg_fcw = '0; cfg_poff = '0;

    // ---- reset state ----
    repeat (3) tick();
    check_eq("rst_cfg_ready", cfg_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sin", sin_out, 0);
    check_eq("rst_cos", cos_out, 0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_release", cfg_ready, 1);

    // ---- quarter-rate tone: hand values ----
    send_cfg(16'h4000, 16'h0000, 1'b1);
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) check_eq("t1_latency_gap", out_valid, 0);
      if (k >= 4) begin
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_sin", sin_out, sin_tbl[(k - 4) % 4]);
        check_eq("t1_cos", cos_out, cos_tbl[(k - 4) % 4]);
      end
    end
    en = 1'b0;
    repeat (4) tick();

    // ---- slow tone, full period plus wrap ----
    send_cfg(16'h0100, 16'h0000, 1'b1);
    clear_cap();
    en = 1'b1;
    repeat (260) tick();
    en = 1'b0;
    repeat (4) tick();
    check_eq("t2_count", sq.size(), 260);
    bad_amp = 0;
    for (int k = 0; k < sq.size(); k++) begin
      check_eq("t2_sin", sq[k], ref_sin(PW'(k * 256)));
      check_eq("t2_cos", cq[k], ref_cos(PW'(k * 256)));
      e = sq[k] * sq[k] + cq[k] * cq[k];
      if (e * 100 < 98 * 2047 * 2047 || e * 100 > 102 * 2047 * 2047) bad_amp++;
    end
    check_eq("t2_amplitude_out_of_band", bad_amp, 0);

    // ---- 90 degree offset: sine follows the unshifted cosine ----
    send_cfg(16'h4000, 16'h4000, 1'b1);
    clear_cap();
    en = 1'b1;
    repeat (8) tick();
    en = 1'b0;
    repeat (4) tick();
    check_eq("t3_count", sq.size(), 8);
    for (int k = 0; k < sq.size(); k++) begin
      check_eq("t3_sin", sq[k], cos_tbl[k % 4]);
      check_eq("t3_cos", cq[k], cos90[k % 4]);
    end

    // ---- mid-stream rate change, then restart with new offset ----
    send_cfg(16'h0100, 16'h0000, 1'b1);
    clear_cap();
    en = 1'b1;
    repeat (10) tick();
    send_cfg(16'h0300, 16'h0000, 1'b0);
    repeat (3) tick();
    send_cfg(16'h0300, 16'h2000, 1'b1);
    repeat (2) tick();
    en = 1'b0;
    repeat (4) tick();
    check_eq("t4_count", sq.size(), 17);
    for (int k = 0; k < sq.size() && k < 17; k++) begin
      check_eq("t4_sin", sq[k], ref_sin(PW'(ph4[k])));
      check_eq("t4_cos", cq[k], ref_cos(PW'(ph4[k])));
    end

    // ---- en gaps and phase_clr alongside an en edge ----
    send_cfg(16'h1000, 16'h0000, 1'b1);
    clear_cap();
    for (int k = 0; k < 9; k++) begin
      en        = en_pat[k];
      phase_clr = clr_pat[k];
      tick();
      check_eq("t5_valid_pattern", out_valid, vld_pat[k]);
      if (k == 4) check_eq("t5_hold_sin", sin_out, ref_sin(16'h0000));
    end
    en = 1'b0;
    phase_clr = 1'b0;
    repeat (2) tick();
    check_eq("t5_count", sq.size(), 3);
    for (int k = 0; k < sq.size() && k < 3; k++) begin
      check_eq("t5_sin", sq[k], ref_sin(PW'(ph5[k])));
      check_eq("t5_cos", cq[k], ref_cos(PW'(ph5[k])));
    end

    // ---- asynchronous reset mid-stream ----
    send_cfg(16'h0100, 16'h0000, 1'b1);
    en = 1'b1;
    repeat (6) tick();
    check_eq("t6_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_sin", sin_out, 0);
    check_eq("t6_rst_cos", cos_out, 0);
    check_eq("t6_rst_ready", cfg_ready, 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_ready_back", cfg_ready, 1);
    check_eq("t6_no_sample", out_valid, 0);
    // fcw and poff were cleared, so every new sample sits at phase 0.
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) check_eq("t6_gap", out_valid, 0);
      if (k >= 4) begin
        check_eq("t6_valid", out_valid, 1);
        check_eq("t6_sin", sin_out, 25);
        check_eq("t6_cos", cos_out, 2047);
      end
    end
    en = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
